// File: rtl/note_player_pkg.sv
// rtl/note_player_pkg.sv - shared widths, note constants and FSM encoding for note_player
package note_player_pkg;

  localparam int STEP_W = 20;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 9;

  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 6'd49;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/frequency_rom.sv
// rtl/frequency_rom.sv - 64-entry note-to-phase-step ROM with registered output
module frequency_rom
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note,
  output logic [STEP_W-1:0] step
);

  // round(440 * 2^((n-49)/12) * 2^20 / 48000); note 0 is a rest and maps to 0
  function automatic logic [STEP_W-1:0] lookup(input logic [NOTE_W-1:0] n);
    case (n)
      6'd1:  lookup = 20'd601;   6'd2:  lookup = 20'd636;   6'd3:  lookup = 20'd674;
      6'd4:  lookup = 20'd714;   6'd5:  lookup = 20'd757;   6'd6:  lookup = 20'd802;
      6'd7:  lookup = 20'd850;   6'd8:  lookup = 20'd900;   6'd9:  lookup = 20'd954;
      6'd10: lookup = 20'd1010;  6'd11: lookup = 20'd1070;  6'd12: lookup = 20'd1134;
      6'd13: lookup = 20'd1201;  6'd14: lookup = 20'd1273;  6'd15: lookup = 20'd1349;
      6'd16: lookup = 20'd1429;  6'd17: lookup = 20'd1514;  6'd18: lookup = 20'd1604;
      6'd19: lookup = 20'd1699;  6'd20: lookup = 20'd1800;  6'd21: lookup = 20'd1907;
      6'd22: lookup = 20'd2021;  6'd23: lookup = 20'd2141;  6'd24: lookup = 20'd2268;
      6'd25: lookup = 20'd2403;  6'd26: lookup = 20'd2546;  6'd27: lookup = 20'd2697;
      6'd28: lookup = 20'd2858;  6'd29: lookup = 20'd3028;  6'd30: lookup = 20'd3208;
      6'd31: lookup = 20'd3398;  6'd32: lookup = 20'd3600;  6'd33: lookup = 20'd3815;
      6'd34: lookup = 20'd4041;  6'd35: lookup = 20'd4282;  6'd36: lookup = 20'd4536;
      6'd37: lookup = 20'd4806;  6'd38: lookup = 20'd5092;  6'd39: lookup = 20'd5395;
      6'd40: lookup = 20'd5715;  6'd41: lookup = 20'd6055;  6'd42: lookup = 20'd6415;
      6'd43: lookup = 20'd6797;  6'd44: lookup = 20'd7201;  6'd45: lookup = 20'd7629;
      6'd46: lookup = 20'd8083;  6'd47: lookup = 20'd8563;  6'd48: lookup = 20'd9072;
      6'd49: lookup = 20'd9612;  6'd50: lookup = 20'd10184; 6'd51: lookup = 20'd10789;
      6'd52: lookup = 20'd11431; 6'd53: lookup = 20'd12110; 6'd54: lookup = 20'd12830;
      6'd55: lookup = 20'd13593; 6'd56: lookup = 20'd14402; 6'd57: lookup = 20'd15258;
      6'd58: lookup = 20'd16165; 6'd59: lookup = 20'd17127; 6'd60: lookup = 20'd18145;
      6'd61: lookup = 20'd19224; 6'd62: lookup = 20'd20367; 6'd63: lookup = 20'd21578;
      default: lookup = 20'd0;
    endcase
  endfunction

  // Registered read: the only cycle of latency between a latched note and its step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step <= '0;
    else        step <= lookup(note);
  end

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - note timer and phase-step gating; NOTE_PLAYER_GAP_EN silences the final beat
module note_player
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_player,
  input  logic              play,
  input  logic              beat,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  duration_in,
  output logic [STEP_W-1:0] step_size,
  output logic              note_active,
  output logic              note_done
);

  state_t             state, state_n;
  logic [DUR_W-1:0]   count, count_n;
  logic [NOTE_W-1:0]  note, note_n;
  logic               done_q, done_n;
  logic               gate_q, gate_n;
  logic [STEP_W-1:0]  rom_step;

  frequency_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .note  (note),
    .step  (rom_step)
  );

  // State, beat counter, note latch and the two output-shaping flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      note   <= NOTE_REST;
      done_q <= 1'b0;
      gate_q <= 1'b0;
    end else if (reset_player) begin
      state  <= IDLE;
      count  <= '0;
      note   <= NOTE_REST;
      done_q <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      note   <= note_n;
      done_q <= done_n;
      gate_q <= gate_n;
    end
  end

  // Next state: a load always wins; otherwise count beats down and finish on 1->0 or a zero duration
  always_comb begin
    state_n = state;
    count_n = count;
    note_n  = note;
    done_n  = 1'b0;
    if (load_new_note) begin
      state_n = ACTIVE;
      count_n = duration_in;
      note_n  = note_in;
    end else if (state == ACTIVE) begin
      if (count == '0) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else if (play && beat) begin
        count_n = count - DUR_W'(1);
        if (count == DUR_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    end
    // Gate lines up with the ROM's one-cycle read so the step and its enable change together
`ifdef NOTE_PLAYER_GAP_EN
    gate_n = (state == ACTIVE) && play && (count != DUR_W'(1));
`else
    gate_n = (state == ACTIVE) && play;
`endif
  end

  // Outputs: silence whenever the gate is closed
  always_comb begin
    note_active = (state == ACTIVE);
    note_done   = done_q;
    step_size   = gate_q ? rom_step : '0;
  end

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - directed self-checking bench for note_player
module tb_note_player;
  import note_player_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              reset_player = 1'b0;
  logic              play = 1'b0;
  logic              beat = 1'b0;
  logic              load_new_note = 1'b0;
  logic [NOTE_W-1:0] note_in = '0;
  logic [DUR_W-1:0]  duration_in = '0;
  logic [STEP_W-1:0] step_size;
  logic              note_active;
  logic              note_done;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] S49 = 32'd9612;
  localparam logic [31:0] S40 = 32'd5715;
  localparam logic [31:0] S52 = 32'd11431;

  note_player dut (
    .clk           (clk),
    .reset         (reset),
    .reset_player  (reset_player),
    .play          (play),
    .beat          (beat),
    .load_new_note (load_new_note),
    .note_in       (note_in),
    .duration_in   (duration_in),
    .step_size     (step_size),
    .note_active   (note_active),
    .note_done     (note_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input int d);
    load_new_note = 1'b1;
    note_in = NOTE_W'(n);
    duration_in = DUR_W'(d);
    tick();
    load_new_note = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_step", 32'(step_size), 0);
    check("rst_active", 32'(note_active), 0);
    check("rst_done", 32'(note_done), 0);
    reset = 1'b1;
    play = 1'b1;
    tick();

    // A4 for three beats
    load(49, 3);
    check("a4_active_t1", 32'(note_active), 1);
    check("a4_step_t1", 32'(step_size), 0);
    tick();
    check("a4_step_t2", 32'(step_size), S49);
    pulse_beat();
    check("a4_step_b1", 32'(step_size), S49);
    check("a4_done_b1", 32'(note_done), 0);
    pulse_beat();
    check("a4_step_b2", 32'(step_size), S49);
    tick();
`ifdef NOTE_PLAYER_GAP_EN
    check("a4_step_gap", 32'(step_size), 0);
`else
    check("a4_step_b3", 32'(step_size), S49);
`endif
    pulse_beat();
    check("a4_done", 32'(note_done), 1);
    check("a4_inactive", 32'(note_active), 0);
    tick();
    check("a4_done_once", 32'(note_done), 0);
    check("a4_step_end", 32'(step_size), 0);

    // Rest note is timed but silent
    load(0, 2);
    tick();
    check("rest_step", 32'(step_size), 0);
    check("rest_active", 32'(note_active), 1);
    pulse_beat();
    check("rest_done_b1", 32'(note_done), 0);
    pulse_beat();
    check("rest_done", 32'(note_done), 1);
    tick();
    check("rest_done_once", 32'(note_done), 0);

    // Pause freezes the counter and silences the output
    load(49, 4);
    tick();
    pulse_beat();
    play = 1'b0;
    tick();
    check("pause_step", 32'(step_size), 0);
    check("pause_active", 32'(note_active), 1);
    for (int i = 0; i < 5; i++) begin
      pulse_beat();
      tick();
      check("pause_done", 32'(note_done), 0);
    end
    play = 1'b1;
    tick();
    check("resume_step", 32'(step_size), S49);
    pulse_beat();
    check("resume_done_b1", 32'(note_done), 0);
    pulse_beat();
    check("resume_done_b2", 32'(note_done), 0);
    pulse_beat();
    check("resume_done_b3", 32'(note_done), 1);
    tick();
    check("resume_step_end", 32'(step_size), 0);

    // Load overrides the final beat of the previous note
    load(40, 2);
    tick();
    check("ovr_step40", 32'(step_size), S40);
    pulse_beat();
    beat = 1'b1;
    load(52, 1);
    beat = 1'b0;
    check("ovr_no_done", 32'(note_done), 0);
    check("ovr_active", 32'(note_active), 1);
    tick();
`ifdef NOTE_PLAYER_GAP_EN
    check("ovr_step52", 32'(step_size), 0);
`else
    check("ovr_step52", 32'(step_size), S52);
`endif
    pulse_beat();
    check("ovr_done", 32'(note_done), 1);
    tick();
    check("ovr_done_once", 32'(note_done), 0);

    // Zero duration finishes without a beat
    load(49, 0);
    check("dur0_active", 32'(note_active), 1);
    check("dur0_done_t1", 32'(note_done), 0);
    tick();
    check("dur0_done", 32'(note_done), 1);
    check("dur0_inactive", 32'(note_active), 0);
    tick();
    check("dur0_done_once", 32'(note_done), 0);

    // Synchronous clear mid-note
    load(49, 5);
    tick();
    tick();
    check("rp_pre_step", 32'(step_size), S49);
    reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    check("rp_active", 32'(note_active), 0);
    check("rp_step", 32'(step_size), 0);
    check("rp_done", 32'(note_done), 0);

    // Synchronous clear beats a coincident load
    reset_player = 1'b1;
    load(49, 3);
    reset_player = 1'b0;
    check("rpld_active", 32'(note_active), 0);
    tick();
    check("rpld_step", 32'(step_size), 0);
    check("rpld_done", 32'(note_done), 0);

    // Beats in IDLE do nothing
    pulse_beat();
    tick();
    check("idle_beat_done", 32'(note_done), 0);
    check("idle_beat_active", 32'(note_active), 0);

    // Asynchronous reset mid-note clears outputs before any edge
    load(49, 5);
    tick();
    tick();
    check("ar_pre_step", 32'(step_size), S49);
    #2;
    reset = 1'b0;
    #1;
    check("ar_step", 32'(step_size), 0);
    check("ar_active", 32'(note_active), 0);
    check("ar_done", 32'(note_done), 0);
    tick();
    reset = 1'b1;
    tick();
    check("ar_after_step", 32'(step_size), 0);
    check("ar_after_active", 32'(note_active), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
